seq_decode_regfile: RTL and testbench
=====================================

Name: seq_decode_regfile

Overview:
- Read side of the SEQ Y86-64 register interface; counterpart to the writeback stage, which produces dstE/dstM.
- Decodes icode/rA/rB into source IDs srcA/srcB and returns valA/valB combinationally from a 15-entry register file.
- Commits writeback results (valE to dstE, valM to dstM) on the rising clock edge.
- Sits between the fetch and execute stages; writeback feeds its write ports.

Parameters:
- DATA_W, 64, register and value width.
- NREG, 15, number of architectural registers (IDs 0..14); ID 15 is RNONE.

Ports:
- clk  input  1  system clock, rising-edge active
- rst  input  1  asynchronous, active-high reset
- icode  input  4  current instruction code
- rA  input  4  register specifier A from fetch
- rB  input  4  register specifier B from fetch
- dstE  input  4  writeback E destination ID (15 = no write)
- dstM  input  4  writeback M destination ID (15 = no write)
- valE  input  DATA_W  value for dstE
- valM  input  DATA_W  value for dstM
- srcA  output  4  decoded source A ID
- srcB  output  4  decoded source B ID
- valA  output  DATA_W  register[srcA], or 0 if srcA = 15
- valB  output  DATA_W  register[srcB], or 0 if srcB = 15
- dbg_rsel  input  4  debug read select
- dbg_rval  output  DATA_W  register[dbg_rsel], or 0 if dbg_rsel = 15

Behaviour:
- Reset: rst high clears all 15 registers to 0 immediately, with no clock needed. Outputs follow combinationally, so valA/valB/dbg_rval read 0. While rst is high, writes are blocked.
- srcA decode:
  - icode 2 (rrmovq/cmov), 4 (rmmovq), 6 (OPq), 0xA (pushq) -> rA
  - icode 0xB (popq), 9 (ret) -> 4 (%rsp)
  - all others -> 15
- srcB decode:
  - icode 4, 5 (mrmovq), 6 -> rB
  - icode 8 (call), 9, 0xA, 0xB -> 4
  - all others -> 15
- Reads are purely combinational from current state, with zero latency.
- No same-cycle bypass: a value written at edge N is visible on valA/valB only after edge N.
- Write, at each rising clk edge with rst low:
  - if dstE != 15, reg[dstE] <= valE
  - if dstM != 15, reg[dstM] <= valM
  - if dstE == dstM != 15, valM wins (popq %rsp semantics); exactly one write to that register.
- ID 15 is never storage; writes to it are dropped silently.
- rA/rB = 15 with an icode that selects them yields src = 15 and val = 0.
- Invalid icodes (0xC..0xF) decode both sources to 15; writes still proceed from dstE/dstM.
- Reset asserted mid-operation overrides any pending edge: the registers hold 0 for the whole time rst is high. The first write lands at the first rising edge after rst falls.
- Width: all values pass through unmodified at DATA_W bits; no sign handling.

Decomposition:
- Shared package y86_pkg holds:
  - icode constants (IHALT..IPOPQ)
  - register IDs (RRSP=4, RNONE=15)
  - DATA_W default
- One natural sub-module: y86_regfile_core holds the storage array, the async-reset clear, the dual write port with M priority, and three read ports.
- seq_decode_regfile wraps y86_regfile_core and adds the srcA/srcB decode logic.

Test Plan:
- Reset clear: pulse rst with no clock, then sweep dbg_rsel 0..14 -> dbg_rval = 0 for every register.
- OPq write/read: edge 1 with dstE=2, valE=0x1234, dstM=15; then icode=6, rA=2, rB=2 -> srcA=srcB=2, valA=valB=0x1234. Before edge 1, valA = 0 (no bypass).
- Conflict: dstE=dstM=4, valE=0x10, valM=0x20, one edge -> reg[4]=0x20. Then icode=0xB -> srcA=4, srcB=4, valA=0x20.
- Stack decode: icode=0xA, rA=5 -> srcA=5, srcB=4. icode=8 -> srcA=15, valA=0, srcB=4. icode=9 -> srcA=srcB=4.
- RNONE: dstE=15, dstM=15 with nonzero valE/valM across 3 edges -> all 15 registers unchanged. icode=2, rA=15 -> valA=0.
- Mid-run reset: registers 0..14 loaded with i+1; raise rst between edges -> all registers read 0 immediately. A write presented during rst is dropped. After rst falls, the next edge with dstE=7, valE=0x99 -> reg[7]=0x99.

Source files
------------

// File: rtl/y86_pkg.sv
// Shared Y86-64 constants: instruction codes, register IDs and the
// source-operand decode rules used by the SEQ decode stage.
package y86_pkg;

  localparam int unsigned Y86_DATA_W = 64;
  localparam int unsigned ID_W       = 4;

  // Instruction codes
  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  // Register IDs
  localparam logic [3:0] RRSP  = 4'h4;
  localparam logic [3:0] RNONE = 4'hF;

  // srcA: rA for register-sourcing ops, %rsp for stack pops, else none
  function automatic logic [3:0] decode_src_a(input logic [3:0] icode,
                                              input logic [3:0] ra);
    logic [3:0] src;
    case (icode)
      IRRMOVQ, IRMMOVQ, IOPQ, IPUSHQ: src = ra;
      IPOPQ, IRET:                    src = RRSP;
      default:                        src = RNONE;
    endcase
    return src;
  endfunction

  // srcB: rB for memory/ALU ops, %rsp for all stack ops, else none
  function automatic logic [3:0] decode_src_b(input logic [3:0] icode,
                                              input logic [3:0] rb);
    logic [3:0] src;
    case (icode)
      IRMMOVQ, IMRMOVQ, IOPQ:      src = rb;
      ICALL, IRET, IPUSHQ, IPOPQ:  src = RRSP;
      default:                     src = RNONE;
    endcase
    return src;
  endfunction

endpackage

// File: rtl/y86_regfile_core.sv
// Y86-64 register storage: async-clear array, dual write port with M-port
// priority, and three combinational read ports. ID RNONE is never storage.
module y86_regfile_core
  import y86_pkg::*;
#(
  parameter int unsigned DATA_W = Y86_DATA_W,
  parameter int unsigned NREG   = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        i_dst_e,
  input  logic [DATA_W-1:0] i_val_e,
  input  logic [3:0]        i_dst_m,
  input  logic [DATA_W-1:0] i_val_m,
  input  logic [3:0]        i_rsel_a,
  input  logic [3:0]        i_rsel_b,
  input  logic [3:0]        i_rsel_d,
  output logic [DATA_W-1:0] o_rval_a,
  output logic [DATA_W-1:0] o_rval_b,
  output logic [DATA_W-1:0] o_rval_d
);

  logic [DATA_W-1:0] r_regs [NREG];

  logic w_we_e;
  logic w_we_m;

  // Write enables: RNONE destinations are silently dropped
  always_comb begin
    w_we_e = (i_dst_e != RNONE);
    w_we_m = (i_dst_m != RNONE);
  end

  // Storage update: async clear, M port wins when both target one register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NREG; i++) begin
        if (w_we_m && (i_dst_m == i[ID_W-1:0])) begin
          r_regs[i] <= i_val_m;
        end else if (w_we_e && (i_dst_e == i[ID_W-1:0])) begin
          r_regs[i] <= i_val_e;
        end
      end
    end
  end

  // Read ports: IDs with no storage behind them (RNONE) read as zero
  always_comb begin
    o_rval_a = '0;
    o_rval_b = '0;
    o_rval_d = '0;
    for (int unsigned i = 0; i < NREG; i++) begin
      if (i_rsel_a == i[ID_W-1:0]) o_rval_a = r_regs[i];
      if (i_rsel_b == i[ID_W-1:0]) o_rval_b = r_regs[i];
      if (i_rsel_d == i[ID_W-1:0]) o_rval_d = r_regs[i];
    end
  end

endmodule

// File: rtl/seq_decode_regfile.sv
// SEQ Y86-64 decode stage: derives srcA/srcB from icode/rA/rB and reads the
// register file combinationally; writeback results commit on the clock edge.
module seq_decode_regfile
  import y86_pkg::*;
#(
  parameter int unsigned DATA_W = Y86_DATA_W,
  parameter int unsigned NREG   = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        icode,
  input  logic [3:0]        rA,
  input  logic [3:0]        rB,
  input  logic [3:0]        dstE,
  input  logic [3:0]        dstM,
  input  logic [DATA_W-1:0] valE,
  input  logic [DATA_W-1:0] valM,
  output logic [3:0]        srcA,
  output logic [3:0]        srcB,
  output logic [DATA_W-1:0] valA,
  output logic [DATA_W-1:0] valB,
  input  logic [3:0]        dbg_rsel,
  output logic [DATA_W-1:0] dbg_rval
);

  logic [3:0] w_src_a;
  logic [3:0] w_src_b;

  // Source-operand decode
  always_comb begin
    w_src_a = decode_src_a(icode, rA);
    w_src_b = decode_src_b(icode, rB);
  end

  assign srcA = w_src_a;
  assign srcB = w_src_b;

  y86_regfile_core #(
    .DATA_W (DATA_W),
    .NREG   (NREG)
  ) u_core (
    .clk      (clk),
    .rst      (rst),
    .i_dst_e  (dstE),
    .i_val_e  (valE),
    .i_dst_m  (dstM),
    .i_val_m  (valM),
    .i_rsel_a (w_src_a),
    .i_rsel_b (w_src_b),
    .i_rsel_d (dbg_rsel),
    .o_rval_a (valA),
    .o_rval_b (valB),
    .o_rval_d (dbg_rval)
  );

endmodule

// File: tb/tb_seq_decode_regfile.sv
module tb_seq_decode_regfile;

  localparam int unsigned DW = 64;

  logic          clk;
  logic          clk_en;
  logic          rst;
  logic [3:0]    icode, rA, rB, dstE, dstM, dbg_rsel;
  logic [DW-1:0] valE, valM;
  logic [3:0]    srcA, srcB;
  logic [DW-1:0] valA, valB, dbg_rval;

  int unsigned n_cmp = 0;
  int unsigned n_mis = 0;

  // Reference register state (index 15 unused)
  logic [DW-1:0] m_regs [15];

  seq_decode_regfile #(
    .DATA_W (DW),
    .NREG   (15)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .icode    (icode),
    .rA       (rA),
    .rB       (rB),
    .dstE     (dstE),
    .dstM     (dstM),
    .valE     (valE),
    .valM     (valM),
    .srcA     (srcA),
    .srcB     (srcB),
    .valA     (valA),
    .valB     (valB),
    .dbg_rsel (dbg_rsel),
    .dbg_rval (dbg_rval)
  );

  initial clk = 1'b0;
  always #5 clk = clk_en ? ~clk : 1'b0;

  task automatic check(input string tag, input logic [DW-1:0] obs,
                       input logic [DW-1:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] ref_src_a(input logic [3:0] ic, input logic [3:0] ra);
    if (ic inside {4'h2, 4'h4, 4'h6, 4'hA}) return ra;
    if (ic inside {4'h9, 4'hB})             return 4'd4;
    return 4'd15;
  endfunction

  function automatic logic [3:0] ref_src_b(input logic [3:0] ic, input logic [3:0] rb);
    if (ic inside {4'h4, 4'h5, 4'h6})        return rb;
    if (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) return 4'd4;
    return 4'd15;
  endfunction

  function automatic logic [DW-1:0] ref_read(input logic [3:0] id);
    return (id == 4'd15) ? '0 : m_regs[id];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 15; i++) m_regs[i] = '0;
  endtask

  // Commit the presented writes to the model (M applied last so it wins)
  task automatic model_write();
    if (dstE != 4'd15) m_regs[dstE] = valE;
    if (dstM != 4'd15) m_regs[dstM] = valM;
  endtask

  // Advance one clock edge; settle to 1 time unit after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_and_model();
    if (!rst) model_write();
    tick();
  endtask

  task automatic check_decode(input string tag);
    check({tag, ".srcA"}, {60'd0, srcA}, {60'd0, ref_src_a(icode, rA)});
    check({tag, ".srcB"}, {60'd0, srcB}, {60'd0, ref_src_b(icode, rB)});
    check({tag, ".valA"}, valA, ref_read(ref_src_a(icode, rA)));
    check({tag, ".valB"}, valB, ref_read(ref_src_b(icode, rB)));
  endtask

  task automatic check_all_regs(input string tag);
    for (int i = 0; i < 15; i++) begin
      dbg_rsel = 4'(i);
      #1;
      check(tag, dbg_rval, ref_read(4'(i)));
    end
  endtask

  initial begin
    clk_en = 1'b0;
    rst = 1'b0;
    icode = 4'h1; rA = 4'hF; rB = 4'hF;
    dstE = 4'hF; dstM = 4'hF; valE = '0; valM = '0; dbg_rsel = 4'h0;

    // Reset clear with no clock running
    #2 rst = 1'b1;
    #3 rst = 1'b0;
    model_clear();
    check_all_regs("reset_clear");
    dbg_rsel = 4'hF; #1;
    check("dbg_rnone", dbg_rval, '0);

    clk_en = 1'b1;
    tick();

    // OPq write then read, with no same-cycle bypass
    dstE = 4'd2; valE = 64'h1234; dstM = 4'hF;
    icode = 4'h6; rA = 4'd2; rB = 4'd2;
    #1;
    check("opq_pre_edge_valA", valA, '0);
    tick_and_model();
    dstE = 4'hF; #1;
    check_decode("opq");
    check("opq_valA_literal", valA, 64'h1234);

    // E/M conflict: M wins
    dstE = 4'd4; valE = 64'h10; dstM = 4'd4; valM = 64'h20;
    tick_and_model();
    dstE = 4'hF; dstM = 4'hF;
    icode = 4'hB; #1;
    check_decode("popq");
    check("conflict_m_wins", valA, 64'h20);

    // Stack decodes
    icode = 4'hA; rA = 4'd5; #1; check_decode("pushq");
    icode = 4'h8; #1; check_decode("call");
    check("call_srcA_none", {60'd0, srcA}, 64'd15);
    icode = 4'h9; #1; check_decode("ret");

    // RNONE writes are dropped
    valE = 64'hDEAD_BEEF; valM = 64'hCAFE_F00D;
    repeat (3) tick_and_model();
    check_all_regs("rnone_unchanged");
    icode = 4'h2; rA = 4'hF; #1;
    check_decode("rrmov_rnone");
    check("rrmov_rnone_valA", valA, '0);

    // Mid-run reset
    dstM = 4'hF;
    for (int i = 0; i < 15; i++) begin
      dstE = 4'(i); valE = 64'(i + 1);
      tick_and_model();
    end
    dstE = 4'hF;
    check_all_regs("loaded");
    rst = 1'b1; #1;
    model_clear();
    check_all_regs("midrun_reset");
    dstE = 4'd3; valE = 64'h55;
    tick_and_model();
    dbg_rsel = 4'd3; #1;
    check("write_during_rst", dbg_rval, '0);
    rst = 1'b0;
    dstE = 4'd7; valE = 64'h99;
    tick_and_model();
    dstE = 4'hF;
    dbg_rsel = 4'd7; #1;
    check("post_reset_write", dbg_rval, 64'h99);
    check_all_regs("post_reset_all");

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      icode = 4'($urandom);
      rA    = 4'($urandom);
      rB    = 4'($urandom);
      dstE  = ($urandom_range(0, 4) == 0) ? 4'hF : 4'($urandom);
      dstM  = ($urandom_range(0, 3) == 0) ? dstE : 4'($urandom);
      valE  = {$urandom, $urandom};
      valM  = {$urandom, $urandom};
      dbg_rsel = 4'($urandom);
      #1;
      check_decode("rand");
      check("rand_dbg", dbg_rval, ref_read(dbg_rsel));
      if ($urandom_range(0, 24) == 0) begin
        rst = 1'b1; #1;
        model_clear();
        check("rand_rst_dbg", dbg_rval, '0);
        #1 rst = 1'b0;
      end
      tick_and_model();
    end
    check_all_regs("final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
